// File: rtl/wb_regfile_pkg.sv
// Shared constants and helpers for the writeback register file slice.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package wb_regfile_pkg;

  localparam int NUM_REGS = 32;
  localparam int IDX_W    = 5;
  localparam int DATA_W   = 32;

  // Link destination for jal/bgezal/jalr.
  localparam logic [IDX_W-1:0]  LINK_REG = 5'd31;

  // Instruction word of a bubble or flushed slot.
  localparam logic [DATA_W-1:0] BUBBLE   = 32'h0;

  typedef enum logic [1:0] {
    WB_SRC_ALU  = 2'd0,
    WB_SRC_MEM  = 2'd1,
    WB_SRC_LINK = 2'd2
  } wb_src_e;

  // Link writes win over memory loads, which win over the ALU result.
  function automatic wb_src_e wb_src_sel(input logic is_link, input logic mem_to_reg);
    if (is_link)         return WB_SRC_LINK;
    else if (mem_to_reg) return WB_SRC_MEM;
    else                 return WB_SRC_ALU;
  endfunction

endpackage

// File: rtl/wb_select.sv
// Writeback data mux and write-enable qualification.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs every cycle.
//
// Ports:
//   RegWrite_W, MemToReg_W, IfJal_W, IfBgezal_W, IfJalr_W : control qualifiers
//   ALU_out_W, Memdata_W, pcadd1_W                         : candidate write data
//   WriteReg_W                                             : destination index
//   wb_en_W                                                : write really happens
//   wb_data_W                                              : selected write value
module wb_select
  import wb_regfile_pkg::*;
(
  input  logic              RegWrite_W,
  input  logic              MemToReg_W,
  input  logic              IfJal_W,
  input  logic              IfBgezal_W,
  input  logic              IfJalr_W,
  input  logic [DATA_W-1:0] ALU_out_W,
  input  logic [DATA_W-1:0] Memdata_W,
  input  logic [DATA_W-1:0] pcadd1_W,
  input  logic [IDX_W-1:0]  WriteReg_W,
  output logic              wb_en_W,
  output logic [DATA_W-1:0] wb_data_W
);

  wb_src_e src;

  always_comb begin
    src = wb_src_sel(IfJal_W | IfBgezal_W | IfJalr_W, MemToReg_W);
    case (src)
      WB_SRC_LINK: wb_data_W = pcadd1_W;
      WB_SRC_MEM:  wb_data_W = Memdata_W;
      default:     wb_data_W = ALU_out_W;
    endcase
  end

  // $0 is hardwired, so a write aimed at it is not a write at all; the
  // hazard/forward unit must not see it as one either.
  assign wb_en_W = RegWrite_W && (WriteReg_W != '0);

endmodule

// File: rtl/wb_regfile.sv
// 32x32 register file at the writeback stage with retired-instruction counter.
// Latency: writes land at the next rising edge; reads are combinational.
// Backpressure: none; a write is accepted every cycle wb_en_W is high.
//
// Optional feature: define WB_REGFILE_BYPASS_EN to forward the in-flight
// writeback value to a read port addressing the register being written.
//
// Ports:
//   clk, rst_n                      : clock, synchronous active-low reset
//   IR_W                            : writeback instruction (0 = bubble)
//   RegWrite_W .. WriteReg_W        : writeback controls and data candidates
//   rs_addr_D/rt_addr_D             : decode read addresses
//   rs_data_D/rt_data_D             : decode read data
//   wb_en_W, wb_data_W              : effective write enable and write value
//   retired_cnt                     : non-bubble instructions retired (wraps)
module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] IR_W,
  input  logic              RegWrite_W,
  input  logic              MemToReg_W,
  input  logic              IfJal_W,
  input  logic              IfBgezal_W,
  input  logic              IfJalr_W,
  input  logic [DATA_W-1:0] ALU_out_W,
  input  logic [DATA_W-1:0] Memdata_W,
  input  logic [DATA_W-1:0] pcadd1_W,
  input  logic [IDX_W-1:0]  WriteReg_W,
  input  logic [IDX_W-1:0]  rs_addr_D,
  input  logic [IDX_W-1:0]  rt_addr_D,
  output logic [DATA_W-1:0] rs_data_D,
  output logic [DATA_W-1:0] rt_data_D,
  output logic              wb_en_W,
  output logic [DATA_W-1:0] wb_data_W,
  output logic [DATA_W-1:0] retired_cnt
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] retired_nxt;

  wb_select u_wb_select (
    .RegWrite_W (RegWrite_W),
    .MemToReg_W (MemToReg_W),
    .IfJal_W    (IfJal_W),
    .IfBgezal_W (IfBgezal_W),
    .IfJalr_W   (IfJalr_W),
    .ALU_out_W  (ALU_out_W),
    .Memdata_W  (Memdata_W),
    .pcadd1_W   (pcadd1_W),
    .WriteReg_W (WriteReg_W),
    .wb_en_W    (wb_en_W),
    .wb_data_W  (wb_data_W)
  );

  // Reset wins over a coincident write. Entry 0 is never written (wb_en_W
  // excludes it) and is masked on read anyway.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_en_W) begin
      regs[WriteReg_W] <= wb_data_W;
    end
  end

  always_comb begin
    rs_data_D = (rs_addr_D == '0) ? '0 : regs[rs_addr_D];
    rt_data_D = (rt_addr_D == '0) ? '0 : regs[rt_addr_D];
`ifdef WB_REGFILE_BYPASS_EN
    // wb_en_W already excludes $0, so forwarding never breaks the hardwired zero.
    if (wb_en_W && (rs_addr_D == WriteReg_W)) rs_data_D = wb_data_W;
    if (wb_en_W && (rt_addr_D == WriteReg_W)) rt_data_D = wb_data_W;
`endif
  end

  // Natural 32-bit overflow gives the wrap to zero.
  assign retired_nxt = (IR_W != BUBBLE) ? retired_cnt + 32'd1 : retired_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) retired_cnt <= '0;
    else        retired_cnt <= retired_nxt;
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus queues expected values for the
// current cycle, a monitor pops and compares them at the falling edge.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] IR_W;
  logic        RegWrite_W, MemToReg_W, IfJal_W, IfBgezal_W, IfJalr_W;
  logic [31:0] ALU_out_W, Memdata_W, pcadd1_W;
  logic [4:0]  WriteReg_W, rs_addr_D, rt_addr_D;
  logic [31:0] rs_data_D, rt_data_D, wb_data_W, retired_cnt;
  logic        wb_en_W;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .IR_W        (IR_W),
    .RegWrite_W  (RegWrite_W),
    .MemToReg_W  (MemToReg_W),
    .IfJal_W     (IfJal_W),
    .IfBgezal_W  (IfBgezal_W),
    .IfJalr_W    (IfJalr_W),
    .ALU_out_W   (ALU_out_W),
    .Memdata_W   (Memdata_W),
    .pcadd1_W    (pcadd1_W),
    .WriteReg_W  (WriteReg_W),
    .rs_addr_D   (rs_addr_D),
    .rt_addr_D   (rt_addr_D),
    .rs_data_D   (rs_data_D),
    .rt_data_D   (rt_data_D),
    .wb_en_W     (wb_en_W),
    .wb_data_W   (wb_data_W),
    .retired_cnt (retired_cnt)
  );

  localparam int S_RS = 0, S_RT = 1, S_EN = 2, S_WD = 3, S_CNT = 4;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  chk_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Monitor: everything queued during a cycle is checked at its falling edge.
  initial begin
    chk_t        c;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        c = sb.pop_front();
        case (c.sel)
          S_RS:    act = rs_data_D;
          S_RT:    act = rt_data_D;
          S_EN:    act = {31'd0, wb_en_W};
          S_WD:    act = wb_data_W;
          default: act = retired_cnt;
        endcase
        n_chk++;
        if (act !== c.exp) begin
          n_fail++;
          $display("FAIL %s: got %h, expected %h", c.name, act, c.exp);
        end
      end
    end
  end

  task automatic expect_val(input string name, input int sel, input logic [31:0] v);
    chk_t c;
    c.name = name;
    c.sel  = sel;
    c.exp  = v;
    sb.push_back(c);
  endtask

  task automatic idle();
    IR_W = 32'h0; RegWrite_W = 1'b0; MemToReg_W = 1'b0;
    IfJal_W = 1'b0; IfBgezal_W = 1'b0; IfJalr_W = 1'b0;
    ALU_out_W = 32'h0; Memdata_W = 32'h0; pcadd1_W = 32'h0;
    WriteReg_W = 5'd0; rs_addr_D = 5'd0; rt_addr_D = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_alu(input logic [4:0] idx, input logic [31:0] v, input logic [31:0] ir);
    idle();
    IR_W = ir; RegWrite_W = 1'b1; WriteReg_W = idx; ALU_out_W = v;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    // Reset with an active write to $3 and a non-bubble instruction.
    RegWrite_W = 1'b1; WriteReg_W = 5'd3; ALU_out_W = 32'hAAAA; IR_W = 32'h1234_5678;
    tick();
    expect_val("rst_wb_en_follows", S_EN, 32'd1);
    expect_val("rst_wb_data_follows", S_WD, 32'hAAAA);
    expect_val("rst_cnt_zero", S_CNT, 32'h0);
    tick();

    rst_n = 1'b1;
    idle();
    rs_addr_D = 5'd3;
    expect_val("rst_write_dropped_r3", S_RS, 32'h0);
    expect_val("cnt_after_rst", S_CNT, 32'h0);
    tick();

    for (int i = 0; i < 32; i++) begin
      rs_addr_D = 5'(i);
      rt_addr_D = 5'(31 - i);
      expect_val($sformatf("rst_rs_r%0d", i), S_RS, 32'h0);
      expect_val($sformatf("rst_rt_r%0d", 31 - i), S_RT, 32'h0);
      tick();
    end

    // ALU write to $5; retires one instruction.
    wr_alu(5'd5, 32'h1234, 32'h00A5_2820);
    expect_val("alu_wb_en", S_EN, 32'd1);
    expect_val("alu_wb_data", S_WD, 32'h1234);
    tick();
    idle();
    rs_addr_D = 5'd5;
    expect_val("alu_read_r5", S_RS, 32'h1234);
    expect_val("cnt_one", S_CNT, 32'd1);
    tick();

    // Link beats memory.
    idle();
    IR_W = 32'h0C00_0010; RegWrite_W = 1'b1; IfJal_W = 1'b1; MemToReg_W = 1'b1;
    WriteReg_W = 5'd31; pcadd1_W = 32'h41; Memdata_W = 32'hDEAD; ALU_out_W = 32'h9;
    expect_val("jal_over_mem_data", S_WD, 32'h41);
    tick();

    // Memory select alone into $10.
    idle();
    IR_W = 32'h8C0A_0000; RegWrite_W = 1'b1; MemToReg_W = 1'b1;
    WriteReg_W = 5'd10; Memdata_W = 32'hDEAD; ALU_out_W = 32'h1;
    rt_addr_D = 5'd31;
    expect_val("jal_read_r31", S_RT, 32'h41);
    expect_val("mem_wb_data", S_WD, 32'hDEAD);
    expect_val("cnt_two", S_CNT, 32'd2);
    tick();

    // bgezal into $11, jalr into $12 (IR kept as bubble to hold the count).
    idle();
    RegWrite_W = 1'b1; IfBgezal_W = 1'b1; WriteReg_W = 5'd11;
    pcadd1_W = 32'h55; ALU_out_W = 32'h2; rs_addr_D = 5'd10;
    expect_val("mem_read_r10", S_RS, 32'hDEAD);
    tick();
    idle();
    RegWrite_W = 1'b1; IfJalr_W = 1'b1; MemToReg_W = 1'b1; WriteReg_W = 5'd12;
    pcadd1_W = 32'h66; Memdata_W = 32'h3; rs_addr_D = 5'd11;
    expect_val("bgezal_read_r11", S_RS, 32'h55);
    expect_val("jalr_wb_data", S_WD, 32'h66);
    tick();
    idle();
    rt_addr_D = 5'd12;
    expect_val("jalr_read_r12", S_RT, 32'h66);
    expect_val("cnt_hold_bubbles", S_CNT, 32'd3);
    tick();

    // Write to $0 is discarded.
    wr_alu(5'd0, 32'hFFFF, 32'h0);
    rs_addr_D = 5'd0;
    expect_val("r0_wb_en_low", S_EN, 32'd0);
    expect_val("r0_wb_data", S_WD, 32'hFFFF);
    expect_val("r0_read_same_cycle", S_RS, 32'h0);
    tick();
    idle();
    rs_addr_D = 5'd0;
    expect_val("r0_read_after", S_RS, 32'h0);
    tick();

    // Same-cycle write/read of $8.
    wr_alu(5'd8, 32'h11, 32'h0);
    tick();
    wr_alu(5'd8, 32'h77, 32'h0);
    rs_addr_D = 5'd8;
    rt_addr_D = 5'd8;
`ifdef WB_REGFILE_BYPASS_EN
    expect_val("r8_same_cycle_rs", S_RS, 32'h77);
    expect_val("r8_same_cycle_rt", S_RT, 32'h77);
`else
    expect_val("r8_same_cycle_rs", S_RS, 32'h11);
    expect_val("r8_same_cycle_rt", S_RT, 32'h11);
`endif
    tick();
    idle();
    rs_addr_D = 5'd8;
    expect_val("r8_next_cycle", S_RS, 32'h77);
    tick();

    // Counter wrap: load the all-ones value through the next-state net.
    idle();
    force dut.retired_nxt = 32'hFFFF_FFFF;
    tick();
    release dut.retired_nxt;
    expect_val("cnt_preload", S_CNT, 32'hFFFF_FFFF);
    IR_W = 32'h0000_0001;
    tick();
    IR_W = 32'h0;
    expect_val("cnt_wrap", S_CNT, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_val($sformatf("cnt_bubble_hold_%0d", i), S_CNT, 32'h0);
    end
    tick();

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
